// File: rtl/score_logger_if.sv
// rtl/score_logger_if.sv - write port of the high-score storage RAM
//
// Purpose : bundles the address/data/write-enable port that score_logger
//           drives into the 32-entry score memory.
// Signals : address - write address
//           data    - write data
//           wren    - write enable, one write per high cycle
// Modports: master - the writer (score_logger)
//           slave  - the storage RAM
interface score_logger_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 10
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;

  modport master (output address, output data, output wren);
  modport slave  (input  address, input  data, input  wren);
endinterface

// File: rtl/score_logger.sv
// rtl/score_logger.sv - game score counter and high-score RAM writer
//
// Purpose : counts points during a game, writes the final score once per game
//           into the score memory at a rolling address, and zero-sweeps the
//           memory after reset or on request (the memory has no reset).
// Ports   : clock        - system clock, rising edge
//           reset        - synchronous, active-high reset
//           game_start   - pulse, a new game begins
//           point        - pulse, one pipe cleared
//           game_over    - level, high while the game-over screen is shown
//           clear_req    - pulse, erase all stored scores
//           mem          - memory write port (address/data/wren), registered
//           score        - live score of the current or most recent game
//           games_logged - number of valid entries, 0..DEPTH
//           busy         - high while the clear sweep runs
module score_logger #(
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 10,
  parameter int MAX_SCORE = 999
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                game_start,
  input  logic                point,
  input  logic                game_over,
  input  logic                clear_req,
  score_logger_if.master      mem,
  output logic [DATA_W-1:0]   score,
  output logic [ADDR_W:0]     games_logged,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_PLAY,
    S_WRITE,
    S_OVER
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   score_q, score_d;
  logic [ADDR_W:0]     logged_q, logged_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wren_q, wren_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    score_d   = score_q;
    logged_d  = logged_q;
    address_d = address_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    // busy is registered alongside wren, so it stays high with the last sweep
    // write and falls on the cycle after it.
    busy_d    = (state_q == S_CLEAR);

    case (state_q)
      S_CLEAR: begin
        wren_d    = 1'b1;
        address_d = clr_ptr_q;
        data_d    = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        // clear_req takes priority over a simultaneous game_start
        if (clear_req) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
          wr_ptr_d  = '0;
          logged_d  = '0;
        end else if (game_start) begin
          state_d = S_PLAY;
          score_d = '0;
        end
      end

      S_PLAY: begin
        // a point arriving with the first game_over cycle still counts
        if (point && (score_q != DATA_W'(MAX_SCORE))) begin
          score_d = score_q + 1'b1;
        end
        if (game_over) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        wren_d    = 1'b1;
        address_d = wr_ptr_q;
        data_d    = score_q;
        // DEPTH == 2**ADDR_W, so natural overflow gives the rolling wrap
        wr_ptr_d  = wr_ptr_q + 1'b1;
        if (logged_q != (ADDR_W + 1)'(DEPTH)) begin
          logged_d = logged_q + 1'b1;
        end
        state_d = S_OVER;
      end

      S_OVER: begin
        // game_start is ignored here; a new game must pass through IDLE
        if (clear_req) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
          wr_ptr_d  = '0;
          logged_d  = '0;
        end else if (!game_over) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      wr_ptr_q  <= '0;
      score_q   <= '0;
      logged_q  <= '0;
      address_q <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      score_q   <= score_d;
      logged_q  <= logged_d;
      address_q <= address_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      busy_q    <= busy_d;
    end
  end

  assign mem.address   = address_q;
  assign mem.data      = data_q;
  assign mem.wren      = wren_q;
  assign score         = score_q;
  assign games_logged  = logged_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_score_logger.sv
// tb/tb_score_logger.sv - self-checking bench for score_logger
module tb_score_logger;
  localparam int DEPTH     = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 10;
  localparam int MAX_SCORE = 999;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic game_start = 1'b0;
  logic point = 1'b0;
  logic game_over = 1'b0;
  logic clear_req = 1'b0;
  logic [DATA_W-1:0] score;
  logic [ADDR_W:0]   games_logged;
  logic              busy;

  score_logger_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  score_logger #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_SCORE(MAX_SCORE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .game_start(game_start),
    .point(point),
    .game_over(game_over),
    .clear_req(clear_req),
    .mem(mem_if),
    .score(score),
    .games_logged(games_logged),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;

  // storage RAM emulation and write log, fed by the memory port
  int ram [DEPTH];
  int wr_log [$];

  // reference model of what the memory and counters should hold
  int exp_mem [DEPTH];
  int exp_ptr = 0;
  int exp_logged = 0;
  int last_score = 0;

  always @(negedge clock) begin
    if (mem_if.wren === 1'b1) begin
      wr_log.push_back(int'(mem_if.address));
      ram[mem_if.address] = int'(mem_if.data);
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 0;
    exp_ptr = 0;
    exp_logged = 0;
  endtask

  task automatic check_ram(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] != exp_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  // Expects the sweep to start on the next edge; abort_at >= 0 fires reset
  // right after that sweep address is seen.
  task automatic sweep(input int abort_at);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("sweep_wren", mem_if.wren, 1);
      check("sweep_addr", mem_if.address, i);
      check("sweep_data", mem_if.data, 0);
      check("sweep_busy", busy, 1);
      if (i == abort_at) begin
        reset = 1'b1;
        tick();
        check("abort_wren", mem_if.wren, 0);
        check("abort_busy", busy, 1);
        reset = 1'b0;
        return;
      end
    end
    tick();
    check("post_sweep_wren", mem_if.wren, 0);
    check("post_sweep_busy", busy, 0);
    check("post_sweep_logged", games_logged, 0);
    model_clear();
  endtask

  task automatic play_game(input int npts, input bit coinc, input int over_cyc,
                           input bit restart, input bit clr_in_over, input int exp_data);
    wr_log.delete();
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    check("start_score", score, 0);
    for (int p = 0; p < npts; p++) begin
      point = 1'b1;
      tick();
      point = 1'b0;
      if ($urandom_range(0, 1) == 1) tick();
    end
    game_over = 1'b1;
    point = coinc;
    tick();
    point = 1'b0;
    check("pre_write_wren", mem_if.wren, 0);
    tick();
    check("write_wren", mem_if.wren, 1);
    check("write_addr", mem_if.address, exp_ptr);
    check("write_data", mem_if.data, exp_data);
    exp_mem[exp_ptr] = exp_data;
    exp_ptr = (exp_ptr + 1) % DEPTH;
    if (exp_logged < DEPTH) exp_logged++;
    last_score = exp_data;
    check("write_logged", games_logged, exp_logged);
    if (clr_in_over) begin
      tick();
      check("over_single_write", wr_log.size(), 1);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      sweep(-1);
      game_over = 1'b0;
      tick();
      return;
    end
    for (int c = 2; c < over_cyc; c++) begin
      if (restart && c == 2) game_start = 1'b1;
      tick();
      game_start = 1'b0;
    end
    game_over = 1'b0;
    tick();
    tick();
    check("writes_per_game", wr_log.size(), 1);
    check("score_hold", score, exp_data);
    check("games_logged", games_logged, exp_logged);
  endtask

  typedef struct {
    int npts;
    bit coinc;
    int over_cyc;
    bit restart;
    int exp_data;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int np;
    bit cn;
    int exp;

    tbl[0] = '{7,    1'b0, 10, 1'b0, 7};
    tbl[1] = '{0,    1'b0, 2,  1'b0, 0};
    tbl[2] = '{4,    1'b1, 4,  1'b1, 5};
    tbl[3] = '{1100, 1'b0, 3,  1'b0, 999};
    tbl[4] = '{998,  1'b1, 2,  1'b0, 999};
    tbl[5] = '{998,  1'b0, 5,  1'b1, 998};

    for (int i = 0; i < DEPTH; i++) ram[i] = int'($urandom_range(1, 1023));
    model_clear();

    // reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_wren", mem_if.wren, 0);
    check("rst_busy", busy, 1);
    check("rst_addr", mem_if.address, 0);
    check("rst_data", mem_if.data, 0);
    check("rst_score", score, 0);
    check("rst_logged", games_logged, 0);
    reset = 1'b0;
    sweep(-1);
    check_ram("ram_after_power_clear");

    // table-driven games
    for (int t = 0; t < 6; t++) begin
      play_game(tbl[t].npts, tbl[t].coinc, tbl[t].over_cyc, tbl[t].restart, 1'b0, tbl[t].exp_data);
    end
    check_ram("ram_after_table");

    // clear_req beats a simultaneous game_start in IDLE
    game_start = 1'b1;
    clear_req = 1'b1;
    tick();
    game_start = 1'b0;
    clear_req = 1'b0;
    sweep(-1);
    check("score_kept_after_clear", score, last_score);
    check_ram("ram_after_idle_clear");

    // 33 games scoring 1..33: address wraps, games_logged saturates
    for (int g = 1; g <= 33; g++) begin
      play_game(g, 1'b0, int'($urandom_range(2, 4)), 1'b0, 1'b0, g);
    end
    check("logged_saturated", games_logged, DEPTH);
    check("entry0_overwritten", ram[0], 33);
    check_ram("ram_after_wrap");

    // clear in OVER after 3 games, next game lands on address 0
    play_game(2, 1'b0, 3, 1'b0, 1'b0, 2);
    play_game(3, 1'b0, 3, 1'b0, 1'b0, 3);
    play_game(4, 1'b0, 3, 1'b0, 1'b1, 4);
    check("logged_after_over_clear", games_logged, 0);
    check_ram("ram_after_over_clear");
    play_game(5, 1'b0, 2, 1'b0, 1'b0, 5);
    check("first_after_clear_logged", games_logged, 1);
    check("first_after_clear_entry0", ram[0], 5);

    // randomized games against the model
    for (int g = 0; g < 40; g++) begin
      np = ($urandom_range(0, 9) == 0) ? int'($urandom_range(990, 1010)) : int'($urandom_range(0, 30));
      cn = 1'($urandom_range(0, 1));
      exp = np + int'(cn);
      if (exp > MAX_SCORE) exp = MAX_SCORE;
      play_game(np, cn, int'($urandom_range(2, 6)), 1'($urandom_range(0, 1)), 1'b0, exp);
    end
    check("rand_logged", games_logged, exp_logged);
    check_ram("ram_after_random");

    // reset at sweep address 10 restarts the sweep from 0
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    sweep(10);
    sweep(-1);
    check_ram("ram_after_aborted_sweep");

    // reset while in WRITE suppresses the write
    play_game(3, 1'b0, 2, 1'b0, 1'b0, 3);
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    point = 1'b1;
    tick();
    point = 1'b0;
    game_over = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("reset_in_write_wren", mem_if.wren, 0);
    check("reset_in_write_logged", games_logged, 0);
    reset = 1'b0;
    game_over = 1'b0;
    sweep(-1);
    check_ram("ram_after_write_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/score_logger.md
Name: score_logger

Overview:
- Upstream feeder for the high-score storage RAM in the FlappyBird design.
- Counts points during a game and, on game over, performs one write of the final score into the 32-entry score memory using a rolling address.
- After reset, and on request, sweeps every entry to zero, because the storage has no reset of its own.
- Drives the storage's address/data/wren port directly. Also exports the live score and a count of logged games for the display logic.

Parameters:
- DEPTH, 32, number of score memory entries; must equal 2**ADDR_W.
- ADDR_W, 5, width of the address output.
- DATA_W, 10, width of a score.
- MAX_SCORE, 999, saturation limit of the score counter; must be less than 2**DATA_W.

Ports:
- clock  in  1  system clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- game_start  in  1  single-cycle pulse; a new game begins.
- point  in  1  single-cycle pulse; the bird has cleared one pipe.
- game_over  in  1  level; held high while the game-over screen is shown.
- clear_req  in  1  single-cycle pulse; erase all stored scores.
- address  out  ADDR_W  memory write address.
- data  out  DATA_W  memory write data.
- wren  out  1  memory write enable; each high cycle performs one write.
- score  out  DATA_W  live score of the current or most recent game.
- games_logged  out  ADDR_W+1  number of valid entries, 0..DEPTH.
- busy  out  1  high while in CLEAR.

Behaviour:
- address, data, wren and busy are registered. score and games_logged are registers.
- Reset values:
  - state=CLEAR; clear pointer, write pointer (wr_ptr), score, games_logged = 0.
  - wren=0, address=0, data=0, busy=1.
- States are CLEAR, IDLE, PLAY, WRITE, OVER.
- CLEAR:
  - One write per cycle: wren=1, data=0, address=clear pointer, pointer increments by 1.
  - After the write to address DEPTH-1, go to IDLE.
  - The sweep takes exactly DEPTH consecutive wren cycles, addresses 0..DEPTH-1 ascending. The first write cycle is the first cycle after reset is sampled low.
  - On entry, wr_ptr and games_logged are forced to 0.
  - busy=1 throughout and drops to 0 with the last write cycle's successor.
  - game_start, point and clear_req are ignored.
- IDLE:
  - wren=0; score holds its last value.
  - game_start goes to PLAY and sets score=0.
  - clear_req goes to CLEAR with the clear pointer at 0.
  - If game_start and clear_req are asserted in the same cycle, clear_req wins.
- PLAY:
  - Each point pulse increments score, saturating at MAX_SCORE (it stays at MAX_SCORE).
  - game_over high goes to WRITE. A point asserted in the same cycle as game_over is counted.
  - game_start and clear_req are ignored.
- WRITE (one cycle):
  - wren=1, address=wr_ptr, data=final score.
  - The wren cycle is exactly 2 cycles after the first cycle game_over is sampled high.
  - After the write, wr_ptr increments modulo DEPTH (31 wraps to 0), so the oldest entry is overwritten.
  - games_logged increments, saturating at DEPTH.
  - Then go to OVER.
- OVER:
  - wren=0; score holds.
  - Go to IDLE when game_over is sampled low.
  - clear_req is honoured here and goes to CLEAR.
  - game_start while game_over is still high is ignored; no restart without passing through IDLE.
- Exactly one write per game. game_over held high for many cycles produces no further writes.
- A score of 0 is still written.
- Reset asserted mid-operation (including mid-CLEAR or in WRITE) aborts it:
  - The cycle after reset is sampled, wren=0.
  - The block then restarts the full CLEAR sweep from address 0.
  - Partially written data is lost by design.
- Any output not listed in a state holds its previous value. address and data are don't-care when wren=0, but must not change except on a write cycle.

Test Plan:
- Reset for 2 cycles, then release -> wren high 32 consecutive cycles, addresses 0..31, data=0, busy=1 throughout; then IDLE with busy=0, games_logged=0.
- game_start, 7 point pulses, game_over high for 10 cycles -> exactly one wren cycle with address=0, data=7; games_logged=1; score stays 7.
- Play 33 games scoring 1..33 -> write addresses 0..31 then 0; entry 0 holds 33; games_logged saturates at 32.
- 1100 point pulses in one game -> score saturates at 999; written data=999.
- point pulse coincident with the first game_over cycle, score previously 4 -> data=5. game_start pulsed while game_over is still high -> ignored, no write, state remains OVER.
- clear_req in OVER after 3 games -> 32-cycle zero sweep; games_logged=0; next game writes address 0. Reset asserted at sweep address 10 -> sweep restarts at address 0.
